// File: rtl/ram_dq_word_bridge_pkg.sv
// Shared definitions for the 32-bit word to 16-bit halfword RAM bridge:
// FSM state encoding and default geometry.
package ram_dq_pkg;

    localparam int RAM_AW_DEF = 14;
    localparam int RAM_DW_DEF = 16;
    localparam int BE_W       = (2 * RAM_DW_DEF) / 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LO   = 3'd1,
        ST_HI   = 3'd2,
        ST_RDL  = 3'd3,
        ST_RSP  = 3'd4
    } state_e;

endpackage

// File: rtl/ram_dq_word_bridge_if.sv
// Word-side request/response channel of the RAM bridge. The master issues
// requests and consumes responses; the slave is the bridge itself.
interface ram_dq_word_bridge_if
    import ram_dq_pkg::*;
#(
    parameter int RAM_AW = RAM_AW_DEF,
    parameter int RAM_DW = RAM_DW_DEF
) ();

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [RAM_AW-2:0]     req_addr;
    logic [BE_W-1:0]       req_be;
    logic [2*RAM_DW-1:0]   req_data;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [2*RAM_DW-1:0]   rsp_data;

    modport master (
        output req_valid, req_we, req_addr, req_be, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_be, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/ram_dq_word_bridge.sv
// Splits each 32-bit word request into a low then a high 16-bit RAM cycle and
// reassembles read data across the RAM's one-cycle registered read.
module ram_dq_word_bridge
    import ram_dq_pkg::*;
#(
    parameter int RAM_AW = RAM_AW_DEF,
    parameter int RAM_DW = RAM_DW_DEF
) (
    input  logic                  clk_i,
    input  logic                  srst_i,
    ram_dq_word_bridge_if.slave   bus,
    output logic                  ram_clock_en_o,
    output logic                  ram_we_o,
    output logic [BE_W/2-1:0]     ram_byte_en_o,
    output logic [RAM_AW-1:0]     ram_address_o,
    output logic [RAM_DW-1:0]     ram_data_o,
    input  logic [RAM_DW-1:0]     ram_q_i
);

    localparam int HBE = BE_W / 2;

    state_e                state_q, state_d;
    logic                  ready_q, ready_d;
    logic                  we_q, we_d;
    logic [RAM_AW-2:0]     addr_q, addr_d;
    logic [HBE-1:0]        be_hi_q, be_hi_d;
    logic [RAM_DW-1:0]     data_hi_q, data_hi_d;
    logic [RAM_DW-1:0]     lo_q, lo_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [2*RAM_DW-1:0]   rsp_data_q, rsp_data_d;
    logic                  ram_ce_q, ram_ce_d;
    logic                  ram_we_q, ram_we_d;
    logic [HBE-1:0]        ram_be_q, ram_be_d;
    logic [RAM_AW-1:0]     ram_addr_q, ram_addr_d;
    logic [RAM_DW-1:0]     ram_data_q, ram_data_d;

    // RAM controls are registered, so each state's RAM cycle is set up on the
    // edge that enters it: the low half is driven straight from the request.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        be_hi_d     = be_hi_q;
        data_hi_d   = data_hi_q;
        lo_d        = lo_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        ram_ce_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_be_d    = ram_be_q;
        ram_addr_d  = ram_addr_q;
        ram_data_d  = ram_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && ready_q) begin
                    we_d       = bus.req_we;
                    addr_d     = bus.req_addr;
                    be_hi_d    = bus.req_be[BE_W-1:HBE];
                    data_hi_d  = bus.req_data[2*RAM_DW-1:RAM_DW];
                    ram_ce_d   = 1'b1;
                    ram_we_d   = bus.req_we;
                    ram_be_d   = bus.req_we ? bus.req_be[HBE-1:0] : '1;
                    ram_addr_d = {bus.req_addr, 1'b0};
                    ram_data_d = bus.req_data[RAM_DW-1:0];
                    state_d    = ST_LO;
                end
            end
            ST_LO: begin
                ram_ce_d   = 1'b1;
                ram_we_d   = we_q;
                ram_be_d   = we_q ? be_hi_q : '1;
                ram_addr_d = {addr_q, 1'b1};
                ram_data_d = data_hi_q;
                state_d    = ST_HI;
            end
            ST_HI: begin
                if (we_q) begin
                    state_d = ST_IDLE;
                end else begin
                    lo_d    = ram_q_i;
                    state_d = ST_RDL;
                end
            end
            ST_RDL: begin
                rsp_data_d  = {ram_q_i, lo_q};
                rsp_valid_d = 1'b1;
                state_d     = ST_RSP;
            end
            ST_RSP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            be_hi_q     <= '0;
            data_hi_q   <= '0;
            lo_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            ram_ce_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_be_q    <= '0;
            ram_addr_q  <= '0;
            ram_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            be_hi_q     <= be_hi_d;
            data_hi_q   <= data_hi_d;
            lo_q        <= lo_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            ram_ce_q    <= ram_ce_d;
            ram_we_q    <= ram_we_d;
            ram_be_q    <= ram_be_d;
            ram_addr_q  <= ram_addr_d;
            ram_data_q  <= ram_data_d;
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign ram_clock_en_o = ram_ce_q;
    assign ram_we_o       = ram_we_q;
    assign ram_byte_en_o  = ram_be_q;
    assign ram_address_o  = ram_addr_q;
    assign ram_data_o     = ram_data_q;

endmodule

// File: tb/tb_ram_dq_word_bridge.sv
// Bench for ram_dq_word_bridge: a halfword RAM model feeds the DUT, while a
// word-level memory model predicts every RAM cycle and every read response.
module tb_ram_dq_word_bridge;

    localparam int AW = 14;
    localparam int DW = 16;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          we;
        logic [1:0]    be;
        logic [DW-1:0] data;
    } ram_cyc_t;

    logic          clk = 1'b0;
    logic          srst;
    logic          ram_ce;
    logic          ram_we;
    logic [1:0]    ram_be;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_q;

    ram_dq_word_bridge_if #(.RAM_AW(AW), .RAM_DW(DW)) bus ();

    ram_dq_word_bridge #(.RAM_AW(AW), .RAM_DW(DW)) dut (
        .clk_i          (clk),
        .srst_i         (srst),
        .bus            (bus),
        .ram_clock_en_o (ram_ce),
        .ram_we_o       (ram_we),
        .ram_byte_en_o  (ram_be),
        .ram_address_o  (ram_addr),
        .ram_data_o     (ram_wdata),
        .ram_q_i        (ram_q)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Halfword RAM with registered read
    logic [DW-1:0] ram_mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_ce === 1'b1) begin
            if (ram_we) begin
                if (ram_be[0]) ram_mem[ram_addr][7:0]  <= ram_wdata[7:0];
                if (ram_be[1]) ram_mem[ram_addr][15:8] <= ram_wdata[15:8];
            end
            ram_q <= ram_mem[ram_addr];
        end
    end

    // Word-level model and expectation queues
    logic [31:0] exp_mem [0:(1<<(AW-1))-1];
    ram_cyc_t    exp_ram_q[$];
    logic [31:0] exp_rsp_q[$];
    logic [32:0] ram_log [0:255];
    int          n_log = 0;
    logic [31:0] last_rsp = 32'h0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Compare process: every RAM cycle and every cycle a response is held
    ram_cyc_t cmp_c;
    always @(negedge clk) begin
        if (ram_ce === 1'b1) begin
            if (n_log < 256) begin
                ram_log[n_log] = {ram_addr, ram_we, ram_be, ram_wdata};
                n_log++;
            end
            if (exp_ram_q.size() == 0) begin
                fail_now("ram_cycle_unexpected");
            end else begin
                cmp_c = exp_ram_q.pop_front();
                check("ram_addr", ram_addr, cmp_c.addr);
                check("ram_we", ram_we, cmp_c.we);
                check("ram_be", ram_be, cmp_c.be);
                check("ram_data", ram_wdata, cmp_c.data);
            end
        end
        if (bus.rsp_valid === 1'b1) begin
            if (exp_rsp_q.size() == 0) begin
                fail_now("rsp_unexpected");
            end else begin
                check("rsp_data", bus.rsp_data, exp_rsp_q[0]);
                if (bus.rsp_ready) begin
                    last_rsp = bus.rsp_data;
                    void'(exp_rsp_q.pop_front());
                end
            end
        end
    end

    // Issue one request; called at posedge+1. abort_lo: caller resets during LO.
    task automatic do_req(input bit we, input logic [AW-2:0] addr, input logic [3:0] be,
                          input logic [31:0] data, input bit abort_lo, output int acc_cyc);
        bit rdy;
        bit accepted;
        ram_cyc_t c;
        accepted = 1'b0;
        acc_cyc = -1;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_be    = be;
        bus.req_data  = data;
        for (int k = 0; k < 40 && !accepted; k++) begin
            @(negedge clk);
            rdy = bus.req_ready;
            @(posedge clk);
            #1;
            if (rdy) accepted = 1'b1;
        end
        bus.req_valid = 1'b0;
        if (!accepted) begin
            fail_now("req_accept_timeout");
            return;
        end
        acc_cyc = cyc;
        c.addr = {addr, 1'b0}; c.we = we; c.be = we ? be[1:0] : 2'b11; c.data = data[15:0];
        exp_ram_q.push_back(c);
        if (!abort_lo) begin
            c.addr = {addr, 1'b1}; c.be = we ? be[3:2] : 2'b11; c.data = data[31:16];
            exp_ram_q.push_back(c);
        end
        if (we) exp_mem[addr] = merge(exp_mem[addr], data, abort_lo ? (be & 4'b0011) : be);
        else    exp_rsp_q.push_back(exp_mem[addr]);
        $display("cycle %0d: %s addr=0x%03h be=%b data=0x%08h%s", cyc, we ? "write" : "read ",
                 addr, be, data, abort_lo ? " (reset during LO)" : "");
    endtask

    task automatic wait_quiet();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (exp_ram_q.size() == 0 && exp_rsp_q.size() == 0 && bus.req_ready === 1'b1) done = 1'b1;
        end
        if (!done) fail_now("quiet_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp_valid(output int seen_cyc);
        seen_cyc = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) begin
                seen_cyc = cyc;
                break;
            end
        end
        if (seen_cyc < 0) fail_now("rsp_valid_timeout");
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, a2, seen, c0;
        for (int i = 0; i < (1 << AW); i++) ram_mem[i] = 16'h0;
        for (int i = 0; i < (1 << (AW-1)); i++) exp_mem[i] = 32'h0;
        ram_mem[14'h040] = 16'h5678; ram_mem[14'h041] = 16'h1234;
        exp_mem[13'h020] = 32'h12345678;
        ram_mem[14'h020] = 16'h5555; ram_mem[14'h021] = 16'hAAAA;
        exp_mem[13'h010] = 32'hAAAA5555;
        ram_q = 16'h0;
        srst = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
        bus.req_be = 4'h0; bus.req_data = 32'h0; bus.rsp_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_ce", ram_ce, 0);
        check("rst_ram_be", ram_be, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_data", ram_wdata, 0);
        @(posedge clk); #1; srst = 1'b0;
        @(negedge clk);
        check("req_ready_reset_cycle", bus.req_ready, 0);
        @(negedge clk);
        check("req_ready_after_reset", bus.req_ready, 1);
        @(posedge clk); #1;

        // Full write then read of 0x005
        do_req(1'b1, 13'h005, 4'hF, 32'hDEADBEEF, 1'b0, a0);
        do_req(1'b0, 13'h005, 4'h0, 32'h0, 1'b0, a1);
        wait_rsp_valid(seen);
        check("read_latency", seen - a1, 3);
        wait_quiet();
        check("lit_ram_lo", ram_log[0], {14'h00A, 1'b1, 2'b11, 16'hBEEF});
        check("lit_ram_hi", ram_log[1], {14'h00B, 1'b1, 2'b11, 16'hDEAD});
        check("lit_read_full", last_rsp, 32'hDEADBEEF);

        // Partial write
        do_req(1'b1, 13'h005, 4'b0110, 32'h11223344, 1'b0, a0);
        do_req(1'b0, 13'h005, 4'h0, 32'h0, 1'b0, a1);
        wait_quiet();
        check("lit_read_partial", last_rsp, 32'hDE2233EF);

        // Response held under back-pressure; new request blocked meanwhile
        bus.rsp_ready = 1'b0;
        do_req(1'b0, 13'h005, 4'h0, 32'h0, 1'b0, a1);
        wait_rsp_valid(seen);
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 13'h020;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_rsp_valid", bus.rsp_valid, 1);
            check("hold_req_ready", bus.req_ready, 0);
            check("hold_rsp_data", bus.rsp_data, 32'hDE2233EF);
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        c0 = cyc;
        do_req(1'b0, 13'h020, 4'h0, 32'h0, 1'b0, a1);
        check("accept_after_rsp_ready", a1 - c0, 2);
        wait_quiet();

        // Back-to-back writes
        do_req(1'b1, 13'h030, 4'hF, 32'h01020304, 1'b0, a0);
        do_req(1'b1, 13'h031, 4'b1001, 32'hA0B0C0D0, 1'b0, a1);
        do_req(1'b1, 13'h032, 4'b0011, 32'h5A5AA5A5, 1'b0, a2);
        check("b2b_gap_1", a1 - a0, 3);
        check("b2b_gap_2", a2 - a1, 3);
        wait_quiet();
        do_req(1'b0, 13'h031, 4'h0, 32'h0, 1'b0, a1);
        wait_quiet();
        check("lit_b2b_readback", last_rsp, 32'hA00000D0);

        // Reset landing on the edge that would start HI
        do_req(1'b1, 13'h010, 4'hF, 32'hCAFEF00D, 1'b1, a0);
        srst = 1'b1;
        @(posedge clk); #1; srst = 1'b0;
        @(negedge clk);
        check("abort_ram_we", ram_we, 0);
        check("abort_ram_ce", ram_ce, 0);
        check("abort_rsp_valid", bus.rsp_valid, 0);
        @(posedge clk); #1;
        do_req(1'b0, 13'h010, 4'h0, 32'h0, 1'b0, a1);
        wait_quiet();
        check("lit_abort_readback", last_rsp, 32'hAAAAF00D);

        // Zero byte enables leave contents alone
        do_req(1'b1, 13'h020, 4'h0, 32'hFFFFFFFF, 1'b0, a0);
        do_req(1'b0, 13'h020, 4'h0, 32'h0, 1'b0, a1);
        wait_quiet();
        check("lit_be0_readback", last_rsp, 32'h12345678);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
